// File: rtl/axis_uart_pkg.sv
// Shared types and constants for the UART TX AXI-Stream scheduler.
package axis_uart_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_HDR  = 2'd1,
    ARB_DATA = 2'd2
  } uart_arb_state_e;

  localparam int UART_HDR_TAG_WIDTH = 4;
  localparam int UART_BYTE_WIDTH    = 8;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_uart_rr_arb.sv
// Combinational round-robin pick: first requester at or after i_rr_ptr, wrapping.
module axis_uart_rr_arb
  import axis_uart_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = idx_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [IDX_W-1:0]   i_rr_ptr,
  output logic [IDX_W-1:0]   o_gnt_idx,
  output logic               o_gnt_any
);

  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_cand;

  always_comb begin
    o_gnt_any = 1'b0;
    o_gnt_idx = '0;
    w_sum     = '0;
    w_cand    = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_sum = {1'b0, i_rr_ptr} + (IDX_W+1)'(k);
      if (w_sum >= (IDX_W+1)'(NUM_SRC)) begin
        w_sum = w_sum - (IDX_W+1)'(NUM_SRC);
      end
      w_cand = w_sum[IDX_W-1:0];
      if (!o_gnt_any && i_req[w_cand]) begin
        o_gnt_any = 1'b1;
        o_gnt_idx = w_cand;
      end
    end
  end

endmodule

// File: rtl/axis_uart_tx_sched.sv
// Packet-granular round-robin scheduler sharing one UART TX byte sink among NUM_SRC sources,
// with an optional {HDR_TAG, src_idx} header byte ahead of each grant.
module axis_uart_tx_sched
  import axis_uart_pkg::*;
#(
  parameter int                                NUM_SRC     = 4,
  parameter bit                                HEADER_EN   = 1'b1,
  parameter logic [UART_HDR_TAG_WIDTH-1:0]     HDR_TAG     = 4'hA,
  parameter int                                MAX_PKT_LEN = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_SRC*8-1:0]   s_axis_tdata_i,
  input  logic [NUM_SRC-1:0]     s_axis_tvalid_i,
  input  logic [NUM_SRC-1:0]     s_axis_tlast_i,
  output logic [NUM_SRC-1:0]     s_axis_tready_o,
  output logic [7:0]             m_axis_tdata_o,
  output logic                   m_axis_tvalid_o,
  input  logic                   m_axis_tready_i,
  output logic [NUM_SRC-1:0]     grant_o,
  output logic                   busy_o,
  output logic [1:0]             state_o
);

  // Handshake: a byte moves on any cycle where valid and ready are both high; once
  // valid is raised the sender holds data stable until that cycle.

  localparam int IDX_W = idx_width(NUM_SRC);
  localparam int CNT_W = $clog2(MAX_PKT_LEN + 1);

  uart_arb_state_e  r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, r_rr_ptr;
  logic [CNT_W-1:0] r_byte_cnt;

  logic [IDX_W-1:0] w_gnt_idx;
  logic             w_gnt_any;
  logic [7:0]       w_src_data;
  logic             w_src_valid;
  logic             w_src_last;
  logic             w_accept;
  logic             w_release;

  axis_uart_rr_arb #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_rr_arb (
    .i_req     (s_axis_tvalid_i),
    .i_rr_ptr  (r_rr_ptr),
    .o_gnt_idx (w_gnt_idx),
    .o_gnt_any (w_gnt_any)
  );

  assign w_src_data  = s_axis_tdata_i[{r_idx, 3'b000} +: 8];
  assign w_src_valid = s_axis_tvalid_i[r_idx];
  assign w_src_last  = s_axis_tlast_i[r_idx];

  assign busy_o  = (r_state != ARB_IDLE);
  assign grant_o = busy_o ? (NUM_SRC'(1) << r_idx) : '0;
  assign state_o = r_state;

  always_comb begin
    w_state_nxt     = r_state;
    m_axis_tvalid_o = 1'b0;
    m_axis_tdata_o  = '0;
    s_axis_tready_o = '0;
    w_accept        = 1'b0;
    w_release       = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_gnt_any) w_state_nxt = HEADER_EN ? ARB_HDR : ARB_DATA;
      end
      ARB_HDR: begin
        m_axis_tvalid_o = 1'b1;
        m_axis_tdata_o  = {HDR_TAG, 4'(r_idx)};
        if (m_axis_tready_i) w_state_nxt = ARB_DATA;
      end
      ARB_DATA: begin
        m_axis_tvalid_o        = w_src_valid;
        m_axis_tdata_o         = w_src_data;
        s_axis_tready_o[r_idx] = m_axis_tready_i;
        w_accept               = w_src_valid && m_axis_tready_i;
        // Release on end of packet or when the payload budget is used up.
        w_release = w_accept &&
                    (w_src_last || (r_byte_cnt == CNT_W'(MAX_PKT_LEN - 1)));
        if (w_release) w_state_nxt = ARB_IDLE;
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ARB_IDLE;
      r_idx      <= '0;
      r_rr_ptr   <= '0;
      r_byte_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ARB_IDLE && w_gnt_any) r_idx <= w_gnt_idx;
      if (w_release) begin
        r_byte_cnt <= '0;
        r_rr_ptr   <= (r_idx == IDX_W'(NUM_SRC - 1)) ? '0 : r_idx + 1'b1;
      end else if (w_accept) begin
        r_byte_cnt <= r_byte_cnt + 1'b1;
      end
    end
  end

endmodule
